// File: rtl/z80_reti_snoop.sv
// Passive Z80 bus monitor: tracks opcode prefixes across M1 fetches and pulses
// O_RETI / O_RETN for one CPU clock-enable period; O_SPM1 flags interrupt acknowledge.
module z80_reti_snoop #(
  parameter bit RETN_EN = 1'b1
) (
  input  logic       I_CLK,
  input  logic       I_RESET_n,
  input  logic       I_CLKEN,
  input  logic       I_M1_n,
  input  logic       I_MREQ_n,
  input  logic       I_IORQ_n,
  input  logic       I_RD_n,
  input  logic [7:0] I_D,
  output logic       O_SPM1,
  output logic       O_RETI,
  output logic       O_RETN
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PFX_ED = 2'd1,
    PFX_CB = 2'd2,
    PFX_IX = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic       fetch_s;
  logic       fetch_r;
  logic       done_s;
  logic       reti_s;
  logic       retn_s;
  logic [7:0] opc_r;

  // Second byte of the ED-prefixed RETN family (ED 4D is RETI, not RETN)
  function automatic logic is_retn(input logic [7:0] opc);
    case (opc)
      8'h45, 8'h55, 8'h5D, 8'h65, 8'h6D, 8'h75, 8'h7D: is_retn = 1'b1;
      default:                                         is_retn = 1'b0;
    endcase
  endfunction

  assign fetch_s = ~I_M1_n & ~I_MREQ_n & ~I_RD_n;
  assign done_s  = I_CLKEN & fetch_r & ~fetch_s;
  // Acknowledge is held low while in reset so peers never see a spurious ack
  assign O_SPM1  = I_RESET_n & ~I_M1_n & ~I_IORQ_n;

  // Prefix decoder: only a completed opcode fetch may move the state
  always_comb begin
    state_s = state_r;
    reti_s  = 1'b0;
    retn_s  = 1'b0;
    if (done_s) begin
      case (state_r)
        IDLE: begin
          case (opc_r)
            8'hED:        state_s = PFX_ED;
            8'hCB:        state_s = PFX_CB;
            8'hDD, 8'hFD: state_s = PFX_IX;
            default:      state_s = IDLE;
          endcase
        end
        PFX_CB: state_s = IDLE;
        PFX_IX: begin
          // DD/FD CB d op: displacement and opcode are plain reads, not M1
          case (opc_r)
            8'hDD, 8'hFD: state_s = PFX_IX;
            8'hED:        state_s = PFX_ED;
            default:      state_s = IDLE;
          endcase
        end
        PFX_ED: begin
          state_s = IDLE;
          if (opc_r == 8'h4D) begin
            reti_s = 1'b1;
          end else if (RETN_EN && is_retn(opc_r)) begin
            retn_s = 1'b1;
          end else begin
            retn_s = 1'b0;
          end
        end
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, fetch tracking and registered pulses advance only on CPU enables
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      state_r <= IDLE;
      fetch_r <= 1'b0;
      opc_r   <= 8'h00;
      O_RETI  <= 1'b0;
      O_RETN  <= 1'b0;
    end else if (I_CLKEN) begin
      fetch_r <= fetch_s;
      if (fetch_s) begin
        opc_r <= I_D;
      end
      state_r <= state_s;
      O_RETI  <= reti_s;
      O_RETN  <= retn_s;
    end
  end

endmodule

// File: tb/tb_z80_reti_snoop.sv
// Bench for z80_reti_snoop: directed scenarios plus randomized bus traffic, checked
// against an instruction-stream model (pending prefix byte) with per-clock comparison.
module tb_z80_reti_snoop;

  logic       I_CLK = 1'b0;
  logic       I_RESET_n;
  logic       I_CLKEN;
  logic       I_M1_n, I_MREQ_n, I_IORQ_n, I_RD_n;
  logic [7:0] I_D;
  logic       spm1_a, reti_a, retn_a;
  logic       spm1_b, reti_b, retn_b;

  z80_reti_snoop #(.RETN_EN(1'b1)) dut_a (
    .I_CLK(I_CLK), .I_RESET_n(I_RESET_n), .I_CLKEN(I_CLKEN), .I_M1_n(I_M1_n),
    .I_MREQ_n(I_MREQ_n), .I_IORQ_n(I_IORQ_n), .I_RD_n(I_RD_n), .I_D(I_D),
    .O_SPM1(spm1_a), .O_RETI(reti_a), .O_RETN(retn_a));

  z80_reti_snoop #(.RETN_EN(1'b0)) dut_b (
    .I_CLK(I_CLK), .I_RESET_n(I_RESET_n), .I_CLKEN(I_CLKEN), .I_M1_n(I_M1_n),
    .I_MREQ_n(I_MREQ_n), .I_IORQ_n(I_IORQ_n), .I_RD_n(I_RD_n), .I_D(I_D),
    .O_SPM1(spm1_b), .O_RETI(reti_b), .O_RETN(retn_b));

  always #5 I_CLK = ~I_CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int div      = 1;
  int cyc      = 0;

  // Model: the pending prefix byte of the instruction being fetched (0 = none)
  logic [7:0] pending;
  logic       prev_fetch;
  logic [7:0] last_d;
  logic       exp_reti, exp_retn;

  // CTC-style observers: samples seen on enabled edges, high clocks, rising edges
  int ctc_reti, ctc_retn, ctc_b, hi_clks, rises;
  logic prev_obs;

  localparam int KF = 0, KMR = 1, KIO = 2, KACK = 3, KMW = 4;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic in_retn_set(input logic [7:0] b);
    logic [7:0] tbl [7];
    tbl = '{8'h45, 8'h55, 8'h5D, 8'h65, 8'h6D, 8'h75, 8'h7D};
    in_retn_set = 1'b0;
    foreach (tbl[i]) if (tbl[i] == b) in_retn_set = 1'b1;
  endfunction

  task automatic model_reset();
    pending = 8'h00; prev_fetch = 1'b0; last_d = 8'h00;
    exp_reti = 1'b0; exp_retn = 1'b0;
  endtask

  // Interpret one completed opcode fetch in the instruction stream
  task automatic model_opcode(input logic [7:0] b);
    if (pending == 8'hED) begin
      exp_reti = (b == 8'h4D);
      exp_retn = in_retn_set(b);
      pending  = 8'h00;
    end else if (pending == 8'hCB) begin
      pending = 8'h00;
    end else if (b == 8'hED || b == 8'hDD || b == 8'hFD || (b == 8'hCB && pending == 8'h00)) begin
      pending = b;
    end else begin
      pending = 8'h00;
    end
  endtask

  task automatic tick();
    logic en, rs, f;
    logic [7:0] d;
    en = I_CLKEN; rs = I_RESET_n; d = I_D;
    f  = !I_M1_n && !I_MREQ_n && !I_RD_n;
    if (en && rs) begin
      ctc_reti += int'(reti_a);
      ctc_retn += int'(retn_a);
      ctc_b    += int'(reti_b) + int'(retn_b);
    end
    @(posedge I_CLK);
    #1;
    if (!rs || !I_RESET_n) begin
      model_reset();
    end else if (en) begin
      exp_reti = 1'b0; exp_retn = 1'b0;
      if (prev_fetch && !f) model_opcode(last_d);
      if (f) last_d = d;
      prev_fetch = f;
    end
    if (reti_a) hi_clks++;
    if (reti_a && !prev_obs) rises++;
    prev_obs = reti_a;
    check("reti_a", reti_a, exp_reti);
    check("retn_a", retn_a, exp_retn);
    check("reti_b", reti_b, exp_reti);
    check("retn_b", retn_b, 1'b0);
    check("spm1_a", spm1_a, I_RESET_n & !I_M1_n & !I_IORQ_n);
    check("spm1_b", spm1_b, I_RESET_n & !I_M1_n & !I_IORQ_n);
    check("excl_a", reti_a & retn_a, 1'b0);
    cyc++;
    I_CLKEN = ((cyc % div) == 0);
  endtask

  task automatic bus(input int kind, input logic [7:0] b);
    I_M1_n   = !(kind == KF || kind == KACK);
    I_MREQ_n = !(kind == KF || kind == KMR || kind == KMW);
    I_IORQ_n = !(kind == KIO || kind == KACK);
    I_RD_n   = !(kind == KF || kind == KMR || kind == KIO);
    I_D      = b;
    repeat (2 * div) tick();
    I_M1_n = 1'b1; I_MREQ_n = 1'b1; I_IORQ_n = 1'b1; I_RD_n = 1'b1;
    I_D = 8'($urandom);
    repeat (div) tick();
  endtask

  task automatic seg_start();
    ctc_reti = 0; ctc_retn = 0; ctc_b = 0; hi_clks = 0; rises = 0;
  endtask

  task automatic seg_end(input string tag, input int n_reti, input int n_retn);
    repeat (3 * div) tick();
    check_int({tag, "_ctc_reti"}, ctc_reti, n_reti);
    check_int({tag, "_ctc_retn"}, ctc_retn, n_retn);
    check_int({tag, "_rises"}, rises, n_reti);
  endtask

  initial begin
    logic [7:0] pick [10];
    int k;
    logic [7:0] b;
    pick = '{8'hED, 8'h4D, 8'h45, 8'h7D, 8'hCB, 8'hDD, 8'hFD, 8'h76, 8'h00, 8'hED};
    I_RESET_n = 1'b0; I_CLKEN = 1'b1;
    I_M1_n = 1'b1; I_MREQ_n = 1'b1; I_IORQ_n = 1'b1; I_RD_n = 1'b1; I_D = 8'h00;
    prev_obs = 1'b0;
    model_reset();
    seg_start();
    // Reset state, including an int-ack pattern that must not raise SPM1
    tick();
    I_M1_n = 1'b0; I_IORQ_n = 1'b0;
    tick();
    I_M1_n = 1'b1; I_IORQ_n = 1'b1;
    tick();
    I_RESET_n = 1'b1;
    tick();

    // T1
    seg_start(); bus(KF, 8'hED); bus(KF, 8'h4D); seg_end("t1", 1, 0);
    check_int("t1_hi_clks", hi_clks, 1);
    // T2
    seg_start(); bus(KF, 8'hCB); bus(KF, 8'hED); bus(KF, 8'h4D); seg_end("t2_cb", 0, 0);
    seg_start(); bus(KF, 8'hED); bus(KF, 8'hED); bus(KF, 8'h4D); seg_end("t2_eded", 0, 0);
    seg_start(); bus(KF, 8'hDD); bus(KF, 8'hED); bus(KF, 8'h4D); seg_end("t2_dd", 1, 0);
    seg_start(); bus(KF, 8'hFD); bus(KF, 8'hDD); bus(KF, 8'hED); bus(KF, 8'h4D);
    seg_end("t2_fddd", 1, 0);
    // T3 (dut_b with RETN disabled must stay silent)
    seg_start(); bus(KF, 8'hED); bus(KF, 8'h45); seg_end("t3", 0, 1);
    check_int("t3_b_silent", ctc_b, 0);
    // T4
    seg_start(); bus(KF, 8'hED); bus(KMR, 8'h4D); bus(KACK, 8'hFF); seg_end("t4_none", 0, 0);
    seg_start(); bus(KF, 8'h4D); seg_end("t4_reti", 1, 0);
    // Back-to-back RETI
    seg_start(); bus(KF, 8'hED); bus(KF, 8'h4D); bus(KF, 8'hED); bus(KF, 8'h4D);
    seg_end("b2b", 2, 0);
    // T5: 1-in-4 enable, pulse spans 4 clocks and is sampled once
    div = 4;
    seg_start(); bus(KF, 8'hED); bus(KF, 8'h4D); seg_end("t5", 1, 0);
    check_int("t5_hi_clks", hi_clks, 4);
    div = 1;
    repeat (4) tick();
    // T6: reset mid-sequence discards the ED prefix
    seg_start(); bus(KF, 8'hED);
    I_RESET_n = 1'b0; tick(); I_RESET_n = 1'b1;
    bus(KF, 8'h4D); seg_end("t6", 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) div = $urandom_range(1, 4);
      if ($urandom_range(0, 99) == 0) begin
        I_RESET_n = 1'b0; tick(); I_RESET_n = 1'b1;
      end
      k = $urandom_range(0, 9);
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pick[$urandom_range(0, 9)];
      if (k <= 5)      bus(KF, b);
      else if (k == 6) bus(KMR, b);
      else if (k == 7) bus(KIO, b);
      else if (k == 8) bus(KACK, b);
      else             bus(KMW, b);
    end
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
